demux_stream_router: RTL and testbench

- Registered, flow-controlled successor to the 20-bit 1-to-16 combinational demultiplexor.
- Routes one input word per cycle to one of CHANNELS output channels selected by an address. Each channel has a one-deep holding register and a valid/ready handshake.
- Sits between the CPU write-back/bus side and per-destination consumers (register banks, I/O ports) that can stall independently.

---
 rtl/demux_pkg.sv | 26 ++
 rtl/demux_slot.sv | 60 ++++++
 rtl/demux_stream_router.sv | 111 +++++++++++
 tb/tb_demux_stream_router.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared constants and helper functions for demux_stream_router.
//            DEFAULT_WIDTH / DEFAULT_CHANNELS : default word width and
//            channel count.
//            addr_width(n) : address bits needed for n channels, minimum 1.
//            in_range(a,n) : 1 when address a selects an existing channel.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int DEFAULT_WIDTH    = 20;
  localparam int DEFAULT_CHANNELS = 16;

  // max(1, clog2(n)); a 1-channel-bit address still needs one wire.
  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_range(input int unsigned addr, input int unsigned n);
    return addr < n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Purpose  : One-deep holding register with valid flag for one output channel.
//            A load always wins over a drain, so a slot that is emptied and
//            refilled on the same edge stays valid with the new word.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            load            - capture load_data on the next edge
//            load_data       - word to capture
//            out_ready       - consumer accepts the held word this cycle
//            valid, data     - held word and its valid flag
//            free            - slot can accept a load this cycle
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      // Drained: data is intentionally left in place.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign free  = ~valid_q | out_ready;

endmodule
`default_nettype wire

// File: rtl/demux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_router
// Purpose  : Registered 1-to-CHANNELS stream demultiplexer. Each accepted
//            word lands in the addressed channel's one-deep slot one cycle
//            later; channels stall independently. Out-of-range addresses are
//            accepted, dropped and flagged with a one-cycle err_addr pulse.
// Ports    : clk, rst_n               - clock, asynchronous active-low reset
//            in_valid/in_ready        - input handshake
//            in_data, in_addr         - input word and destination channel
//            out_valid/out_ready      - per-channel handshake (bit k = ch k)
//            out_data                 - channel k at [k*WIDTH +: WIDTH]
//            err_addr                 - dropped out-of-range word pulse
//            in_bcast                 - (DEMUX_BROADCAST_EN only) load every
//                                       channel at once
// Macro    : DEMUX_BROADCAST_EN enables the broadcast input.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_router
  import demux_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int ADDR_W   = addr_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef DEMUX_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [ADDR_W-1:0]         in_addr,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err_addr
);

  // Free flags padded to the full address span so any in_addr value is a
  // legal index; padding bits are never selected because of addr_ok.
  localparam int ADDR_SPAN = 1 << ADDR_W;

  logic [CHANNELS-1:0]  slot_free;
  logic [CHANNELS-1:0]  slot_load;
  logic [ADDR_SPAN-1:0] free_span;
  logic                 addr_ok;
  logic                 bcast;
  logic                 accept;
  logic                 err_addr_d, err_addr_q;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  always_comb begin
    free_span                 = '0;
    free_span[CHANNELS-1:0]   = slot_free;
  end

  assign addr_ok = in_range(32'(in_addr), 32'(CHANNELS));

  always_comb begin
    in_ready = 1'b1;                     // out-of-range words are sunk
    if (bcast) begin
      in_ready = &slot_free;
    end else if (addr_ok) begin
      in_ready = free_span[in_addr];
    end
  end

  // in_valid gates every state update, so an undriven in_addr while idle
  // cannot disturb any slot or the error flag.
  assign accept = in_valid & in_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    assign slot_load[k] = accept & (bcast | (addr_ok & (in_addr == ADDR_W'(k))));

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .free      (slot_free[k])
    );
  end

  always_comb begin
    err_addr_d = accept & ~bcast & ~addr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr_q <= 1'b0;
    end else begin
      err_addr_q <= err_addr_d;
    end
  end

  assign err_addr = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_stream_router
// Purpose  : Self-checking bench for demux_stream_router. Stimulus pushes
//            expected words into per-channel scoreboard queues; a monitor on
//            the falling edge compares every channel, in_ready and err_addr
//            against that model. A second 10-channel instance covers
//            out-of-range addresses.
// Macro    : DEMUX_BROADCAST_EN adds the broadcast scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_stream_router;

  localparam int W       = 20;
  localparam int CH      = 16;
  localparam int CH10    = 10;
  localparam int TIMEOUT = 300;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_bcast;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [3:0]        in_addr;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready;
  logic [CH*W-1:0]   out_data;
  logic              err_addr;

  logic              in_valid10;
  logic              in_ready10;
  logic [W-1:0]      in_data10;
  logic [3:0]        in_addr10;
  logic [CH10-1:0]   out_valid10;
  logic [CH10-1:0]   out_ready10;
  logic [CH10*W-1:0] out_data10;
  logic              err10;
  logic              in_bcast10;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: words expected on each channel, oldest first.
  logic [W-1:0] exp_q [CH][$];
  logic         err_exp;

  always #5 clk = ~clk;

  demux_stream_router #(.WIDTH(W), .CHANNELS(CH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_addr  (err_addr)
  );

  demux_stream_router #(.WIDTH(W), .CHANNELS(CH10)) u_dut10 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast  (in_bcast10),
`endif
    .in_valid  (in_valid10),
    .in_ready  (in_ready10),
    .in_data   (in_data10),
    .in_addr   (in_addr10),
    .out_valid (out_valid10),
    .out_ready (out_ready10),
    .out_data  (out_data10),
    .err_addr  (err10)
  );

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one word and hold it until the router takes it. Called at
  // posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int addr, input logic [W-1:0] data,
                      input logic bc, output int waits);
    logic acc;
    acc      = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_addr  = 4'(addr);
    in_data  = data;
    in_bcast = bc;
    for (int i = 0; i < TIMEOUT && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    check(acc, "send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  // Monitor / reference model, evaluated away from the active edge.
  always @(negedge clk) begin
    logic [CH-1:0] free_m;
    logic          rdy_m;
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) exp_q[k].delete();
      err_exp = 1'b0;
      check(out_valid == '0, "rst_out_valid", 64'(out_valid), 64'd0);
    end else begin
      for (int k = 0; k < CH; k++) begin
        check(out_valid[k] == (exp_q[k].size() != 0), "out_valid",
              64'(out_valid[k]), 64'(exp_q[k].size() != 0));
        if (out_valid[k] && exp_q[k].size() != 0)
          check(out_data[k*W +: W] == exp_q[k][0], "out_data",
                64'(out_data[k*W +: W]), 64'(exp_q[k][0]));
        free_m[k] = (exp_q[k].size() == 0) || out_ready[k];
      end
      check(err_addr == err_exp, "err_addr", 64'(err_addr), 64'(err_exp));

      if (in_bcast)             rdy_m = &free_m;
      else if (int'(in_addr) < CH) rdy_m = free_m[in_addr];
      else                      rdy_m = 1'b1;
      check(in_ready == rdy_m, "in_ready", 64'(in_ready), 64'(rdy_m));

      // State change expected at the coming rising edge.
      for (int k = 0; k < CH; k++)
        if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
      err_exp = 1'b0;
      if (in_valid && rdy_m) begin
        if (in_bcast)                for (int k = 0; k < CH; k++) exp_q[k].push_back(in_data);
        else if (int'(in_addr) < CH) exp_q[in_addr].push_back(in_data);
        else                         err_exp = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w, tot;
    bit  rnd_done;
    logic [W-1:0] lane;

    rst_n = 1'b0;  in_valid = 0; in_bcast = 0; in_addr = 0; in_data = 0;
    out_ready = '1;
    in_valid10 = 0; in_addr10 = 0; in_data10 = 0; out_ready10 = '1; in_bcast10 = 0;
    repeat (2) @(posedge clk);
    #1;
    check(out_valid == '0, "reset_valid", 64'(out_valid), 64'd0);
    check(out_data == '0, "reset_data", 64'(|out_data), 64'd0);
    check(err_addr == 1'b0, "reset_err", 64'(err_addr), 64'd0);
    check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sweep every channel with all consumers ready.
    tot = 0;
    for (int k = 0; k < CH; k++) begin
      send(k, 20'hA5A5A + 20'(k), 1'b0, w);
      tot += w;
    end
    check(tot == 0, "sweep_stalls", 64'(tot), 64'd0);
    check(out_valid == 16'h8000, "sweep_last_valid", 64'(out_valid), 64'h8000);
    check(out_data[15*W +: W] == 20'hA5A69, "sweep_last_data",
          64'(out_data[15*W +: W]), 64'hA5A69);
    @(posedge clk); #1;

    // Stall isolation on channel 3.
    out_ready = '1;
    out_ready[3] = 1'b0;
    fork
      begin
        send(3, 20'h00011, 1'b0, w);
        send(3, 20'h00022, 1'b0, w);
        send(5, 20'h00033, 1'b0, w);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check(in_ready == 1'b0, "iso_held", 64'(in_ready), 64'd0);
        check(out_valid[5] == 1'b0, "iso_ch5_blocked", 64'(out_valid[5]), 64'd0);
        out_ready[3] = 1'b1;
      end
    join
    repeat (2) @(posedge clk); #1;

    // Drain and refill on channel 7 with no bubbles.
    out_ready = '1;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(7, 20'h70000 + 20'(i), 1'b0, w);
      tot += w;
      check(out_valid[7] == 1'b1, "refill_valid", 64'(out_valid[7]), 64'd1);
      check(out_data[7*W +: W] == 20'h70000 + 20'(i), "refill_data",
            64'(out_data[7*W +: W]), 64'(20'h70000 + 20'(i)));
    end
    check(tot == 0, "refill_stalls", 64'(tot), 64'd0);
    @(posedge clk); #1;

    // Out-of-range addresses on the 10-channel instance.
    for (int a = 10; a <= 12; a += 2) begin
      in_valid10 = 1'b1; in_addr10 = 4'(a); in_data10 = 20'h0BAD0;
      #1;
      check(in_ready10 == 1'b1, "oor_in_ready", 64'(in_ready10), 64'd1);
      @(posedge clk); #1;
      in_valid10 = 1'b0;
      check(err10 == 1'b1, "oor_err_pulse", 64'(err10), 64'd1);
      check(out_valid10 == '0, "oor_no_valid", 64'(out_valid10), 64'd0);
      @(posedge clk); #1;
      check(err10 == 1'b0, "oor_err_one_cycle", 64'(err10), 64'd0);
    end
    in_valid10 = 1'b1; in_addr10 = 4'd9; in_data10 = 20'h99999;
    out_ready10 = '0;
    @(posedge clk); #1;
    in_valid10 = 1'b0;
    check(out_valid10 == 10'h200, "ch9_valid", 64'(out_valid10), 64'h200);
    check(out_data10[9*W +: W] == 20'h99999, "ch9_data", 64'(out_data10[9*W +: W]), 64'h99999);
    check(err10 == 1'b0, "ch9_no_err", 64'(err10), 64'd0);
    out_ready10 = '1;

    // Reset while channels 2 and 9 hold stalled words.
    out_ready = '0;
    send(2, 20'h22222, 1'b0, w);
    send(9, 20'h99999, 1'b0, w);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(out_valid == '0, "midrst_valid", 64'(out_valid), 64'd0);
    check(out_data == '0, "midrst_data", 64'(|out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = '1;
    @(posedge clk); #1;
    send(0, 20'h12345, 1'b0, w);
    check(out_valid == 16'h0001, "postrst_valid", 64'(out_valid), 64'h1);
    check(out_data[W-1:0] == 20'h12345, "postrst_data", 64'(out_data[W-1:0]), 64'h12345);
    @(posedge clk); #1;

`ifdef DEMUX_BROADCAST_EN
    // Broadcast waits for every slot, then fills all channels at once.
    out_ready = '1;
    out_ready[4] = 1'b0;
    send(4, 20'h44444, 1'b0, w);
    fork
      send(0, 20'hFFFFF, 1'b1, w);
      begin
        repeat (4) @(posedge clk);
        #1;
        check(in_ready == 1'b0, "bcast_blocked", 64'(in_ready), 64'd0);
        out_ready[4] = 1'b1;
      end
    join
    check(w == 4, "bcast_waits", 64'(w), 64'd4);
    check(out_valid == '1, "bcast_all_valid", 64'(out_valid), 64'hFFFF);
    for (int k = 0; k < CH; k++) begin
      lane = out_data[k*W +: W];
      check(lane == 20'hFFFFF, "bcast_data", 64'(lane), 64'hFFFFF);
    end
    @(posedge clk); #1;
`endif

    // Randomized traffic with randomly stalling consumers.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic bc;
`ifdef DEMUX_BROADCAST_EN
          bc = ($urandom_range(15) == 0);
`else
          bc = 1'b0;
`endif
          send(int'($urandom_range(CH - 1)), W'($urandom), bc, w);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = CH'($urandom);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = '1;
    repeat (4) @(posedge clk);
    #1;
    tot = 0;
    for (int k = 0; k < CH; k++) tot += exp_q[k].size();
    check(tot == 0 && out_valid == '0, "final_drain", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
